// File: rtl/imem_arbiter.sv
// Instruction-memory arbiter: shares one combinational instruction ROM
// between a fetch port and a debug port. Each access takes three cycles
// (IDLE sample -> READ -> RESP ack). Fetch normally has priority. Debug is
// forced through after STARVE_LIMIT consecutive fetch wins while it waits.
module imem_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ack,
    output logic        if_err,
    output logic [31:0] if_data,
    input  logic        dbg_req,
    input  logic [31:0] dbg_addr,
    output logic        dbg_ack,
    output logic        dbg_err,
    output logic [31:0] dbg_data,
    output logic        mem_ce,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_data
);

    localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [CNT_W-1:0] r_starve_cnt;
    logic [31:0]      r_addr;
    logic             r_sel_dbg;      // 1 = debug port owns the access in flight
    logic [31:0]      r_if_data;
    logic [31:0]      r_dbg_data;
    logic             r_if_err;
    logic             r_dbg_err;

    logic             w_any_req;
    logic             w_grant_dbg;
    logic             w_aligned;
    logic             w_rom_en;

    assign w_any_req   = if_req | dbg_req;
    // Debug wins when alone, or when it has been passed over STARVE_LIMIT times.
    assign w_grant_dbg = dbg_req & (~if_req | (r_starve_cnt == LIMIT_C));
    assign w_aligned   = (r_addr[1:0] == 2'b00);
    assign w_rom_en    = (r_state == ST_READ) & w_aligned;

    // State register; reset abandons any access in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: fixed three-cycle sequence once a request is sampled.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (w_any_req) w_next_state = ST_READ;
            ST_READ: w_next_state = ST_RESP;
            ST_RESP: w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Grant: latch winner's address and port, and track debug starvation.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr       <= 32'h0;
            r_sel_dbg    <= 1'b0;
            r_starve_cnt <= '0;
        end else if ((r_state == ST_IDLE) && w_any_req) begin
            r_sel_dbg <= w_grant_dbg;
            r_addr    <= w_grant_dbg ? dbg_addr : if_addr;
            if (w_grant_dbg) begin
                r_starve_cnt <= '0;
            end else if (dbg_req && (r_starve_cnt != LIMIT_C)) begin
                r_starve_cnt <= r_starve_cnt + CNT_W'(1);
            end
        end
    end

    // Read: capture ROM data (or zero plus error on misalignment) for the winner only.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_if_data  <= 32'h0;
            r_if_err   <= 1'b0;
            r_dbg_data <= 32'h0;
            r_dbg_err  <= 1'b0;
        end else if (r_state == ST_READ) begin
            if (r_sel_dbg) begin
                r_dbg_data <= w_aligned ? mem_data : 32'h0;
                r_dbg_err  <= ~w_aligned;
            end else begin
                r_if_data  <= w_aligned ? mem_data : 32'h0;
                r_if_err   <= ~w_aligned;
            end
        end
    end

    assign mem_ce   = w_rom_en;
    assign mem_addr = w_rom_en ? r_addr : 32'h0;

    assign if_ack   = (r_state == ST_RESP) & ~r_sel_dbg;
    assign dbg_ack  = (r_state == ST_RESP) &  r_sel_dbg;
    assign if_data  = r_if_data;
    assign if_err   = r_if_err;
    assign dbg_data = r_dbg_data;
    assign dbg_err  = r_dbg_err;

endmodule

// File: tb/tb_imem_arbiter.sv
// Bench for imem_arbiter: directed scenarios followed by randomized traffic on
// both ports. Drivers push the expected response per port into queues; an
// independent monitor pops and compares on every ack.
module tb_imem_arbiter;

    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ack;
    logic        if_err;
    logic [31:0] if_data;
    logic        dbg_req;
    logic [31:0] dbg_addr;
    logic        dbg_ack;
    logic        dbg_err;
    logic [31:0] dbg_data;
    logic        mem_ce;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;

    logic [31:0] mem [16];

    typedef struct {
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t  q_if[$];
    exp_t  q_dbg[$];
    exp_t  mon_e;
    int    n_chk = 0;
    int    n_err = 0;
    int    cyc = 0;
    string ack_log = "";
    int    ack_times[$];
    int    fetch_while_dbg = 0;
    logic  dbg_req_q = 1'b0;

    imem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk      (clk),
        .rst      (rst),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_ack   (if_ack),
        .if_err   (if_err),
        .if_data  (if_data),
        .dbg_req  (dbg_req),
        .dbg_addr (dbg_addr),
        .dbg_ack  (dbg_ack),
        .dbg_err  (dbg_err),
        .dbg_data (dbg_data),
        .mem_ce   (mem_ce),
        .mem_addr (mem_addr),
        .mem_data (mem_data)
    );

    // Combinational ROM model, 16 words
    assign mem_data = mem[mem_addr[5:2]];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc       <= cyc + 1;
        dbg_req_q <= dbg_req;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] model_data(input logic [31:0] a);
        return (a[1:0] != 2'b00) ? 32'h0 : mem[a[5:2]];
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic push_exp(input bit is_dbg, input logic [31:0] a);
        exp_t x;
        x.data = model_data(a);
        x.err  = (a[1:0] != 2'b00);
        if (is_dbg) q_dbg.push_back(x);
        else        q_if.push_back(x);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_if_ack"},   32'(if_ack),   32'h0);
        chk({tag, "_dbg_ack"},  32'(dbg_ack),  32'h0);
        chk({tag, "_if_err"},   32'(if_err),   32'h0);
        chk({tag, "_dbg_err"},  32'(dbg_err),  32'h0);
        chk({tag, "_if_data"},  if_data,       32'h0);
        chk({tag, "_dbg_data"}, dbg_data,      32'h0);
        chk({tag, "_mem_ce"},   32'(mem_ce),   32'h0);
        chk({tag, "_mem_addr"}, mem_addr,      32'h0);
    endtask

    function automatic logic [31:0] rand_addr(input bit allow_misaligned);
        logic [1:0] lo;
        lo = 2'b00;
        if (allow_misaligned && ($urandom_range(0, 4) == 0)) lo = 2'($urandom_range(1, 3));
        return {26'd0, 4'($urandom_range(0, 15)), lo};
    endfunction

    // Monitor: score every ack against the per-port expectation queues and
    // watch the memory bus and the starvation bound.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            chk("ack_overlap", 32'(if_ack & dbg_ack), 32'h0);
            if (mem_ce) begin
                chk("mem_addr_aligned", 32'(mem_addr[1:0]), 32'h0);
                chk("mem_addr_range", 32'(mem_addr < 32'd64), 32'h1);
            end else begin
                chk("mem_addr_idle", mem_addr, 32'h0);
            end
            if (if_ack) begin
                ack_log = {ack_log, "F"};
                ack_times.push_back(cyc);
                if (dbg_req_q) fetch_while_dbg++;
                if (q_if.size() == 0) begin
                    n_chk++; n_err++;
                    $display("FAIL if_ack_spurious: got ack with no request outstanding");
                end else begin
                    mon_e = q_if.pop_front();
                    chk("if_data", if_data, mon_e.data);
                    chk("if_err", 32'(if_err), 32'(mon_e.err));
                end
            end
            if (dbg_ack) begin
                ack_log = {ack_log, "D"};
                ack_times.push_back(cyc);
                chk("dbg_starve_bound", 32'(fetch_while_dbg <= LIMIT + 1), 32'h1);
                fetch_while_dbg = 0;
                if (q_dbg.size() == 0) begin
                    n_chk++; n_err++;
                    $display("FAIL dbg_ack_spurious: got ack with no request outstanding");
                end else begin
                    mon_e = q_dbg.pop_front();
                    chk("dbg_data", dbg_data, mon_e.data);
                    chk("dbg_err", 32'(dbg_err), 32'(mon_e.err));
                end
            end
        end
    end

    task automatic drive_port(input bit is_dbg, input int n);
        bit keep;
        keep = 1'b0;
        for (int i = 0; i < n; i++) begin
            logic [31:0] a;
            bit got;
            if (!keep) begin
                repeat ($urandom_range(0, 3)) @(negedge clk);
                @(negedge clk);
            end
            a = rand_addr(1'b1);
            if (is_dbg) begin dbg_addr = a; dbg_req = 1'b1; end
            else        begin if_addr  = a; if_req  = 1'b1; end
            push_exp(is_dbg, a);
            got = 1'b0;
            for (int w = 0; w < 60 && !got; w++) begin
                @(negedge clk);
                got = is_dbg ? dbg_ack : if_ack;
            end
            if (!got) begin
                n_chk++; n_err++;
                $display("FAIL %s_timeout: no ack within 60 cycles", is_dbg ? "dbg" : "if");
                if (is_dbg) dbg_req = 1'b0; else if_req = 1'b0;
                break;
            end
            keep = ($urandom_range(0, 1) == 1) && (i < n - 1);
            if (!keep) begin
                if (is_dbg) dbg_req = 1'b0; else if_req = 1'b0;
            end
        end
    endtask

    initial begin
        logic [31:0] if_keep;
        int          n_total;

        mem[0] = 32'h34011100;
        mem[1] = 32'h34020020;
        for (int i = 2; i < 16; i++) mem[i] = $urandom;
        rst = 1'b1; if_req = 1'b0; dbg_req = 1'b0; if_addr = 32'h0; dbg_addr = 32'h0;
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");

        // Single fetch at word 1, issued in the first cycle after reset release
        rst = 1'b0; if_req = 1'b1; if_addr = 32'h4; push_exp(1'b0, 32'h4);
        @(negedge clk);
        chk("r34_mem_ce", 32'(mem_ce), 32'h1);
        chk("r34_mem_addr", mem_addr, 32'h4);
        chk("r34_ack_early", 32'(if_ack), 32'h0);
        @(negedge clk);
        chk("r34_if_ack", 32'(if_ack), 32'h1);
        chk("r34_if_data", if_data, 32'h34020020);
        if_req = 1'b0;
        @(negedge clk);
        chk("r34_ack_one_cycle", 32'(if_ack), 32'h0);

        // Simultaneous requests: fetch first, debug three cycles later
        if_req = 1'b1; if_addr = 32'h0; push_exp(1'b0, 32'h0);
        dbg_req = 1'b1; dbg_addr = 32'h4; push_exp(1'b1, 32'h4);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            chk($sformatf("r35_if_ack_%0d", k), 32'(if_ack), 32'(k == 2));
            chk($sformatf("r35_dbg_ack_%0d", k), 32'(dbg_ack), 32'(k == 5));
            if (k == 2) chk("r35_if_data", if_data, 32'h34011100);
            if (k == 5) chk("r35_dbg_data", dbg_data, 32'h34020020);
            if (if_ack) if_req = 1'b0;
            if (dbg_ack) dbg_req = 1'b0;
        end

        // Both ports held continuously: debug forced in after LIMIT fetch wins
        ack_log = "";
        ack_times.delete();
        if_addr = rand_addr(1'b0); push_exp(1'b0, if_addr); if_req = 1'b1;
        dbg_addr = rand_addr(1'b0); push_exp(1'b1, dbg_addr); dbg_req = 1'b1;
        n_total = 0;
        for (int k = 0; k < 80 && (q_if.size() > 0 || q_dbg.size() > 0); k++) begin
            @(negedge clk);
            if (if_ack) begin
                n_total++;
                if (n_total < 11) begin if_addr = rand_addr(1'b0); push_exp(1'b0, if_addr); end
                else if_req = 1'b0;
            end
            if (dbg_ack) begin
                n_total++;
                if (n_total < 11) begin dbg_addr = rand_addr(1'b0); push_exp(1'b1, dbg_addr); end
                else dbg_req = 1'b0;
            end
        end
        if_req = 1'b0; dbg_req = 1'b0;
        n_chk++;
        if (ack_log != "FFFFDFFFFDFD") begin
            n_err++;
            $display("FAIL r36_order: got %s expected FFFFDFFFFDFD", ack_log);
        end
        for (int i = 1; i < ack_times.size(); i++)
            chk($sformatf("r36_interval_%0d", i), 32'(ack_times[i] - ack_times[i-1]), 32'd3);
        @(negedge clk);
        chk("r36_drained", 32'(q_if.size() + q_dbg.size()), 32'h0);

        // Misaligned debug read, then an aligned one clears the error
        if_keep = if_data;
        dbg_req = 1'b1; dbg_addr = 32'h6; push_exp(1'b1, 32'h6);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (k <= 2) chk($sformatf("r37_mem_ce_%0d", k), 32'(mem_ce), 32'h0);
            if (k == 2) begin
                chk("r37_dbg_ack", 32'(dbg_ack), 32'h1);
                chk("r37_dbg_err", 32'(dbg_err), 32'h1);
                chk("r37_dbg_data", dbg_data, 32'h0);
                dbg_addr = 32'h8; push_exp(1'b1, 32'h8);
            end
            if (k == 4) begin
                chk("r37_mem_ce_aligned", 32'(mem_ce), 32'h1);
                chk("r37_mem_addr_aligned", mem_addr, 32'h8);
            end
            if (k == 5) begin
                chk("r37_dbg_ack2", 32'(dbg_ack), 32'h1);
                chk("r37_dbg_err_clr", 32'(dbg_err), 32'h0);
                chk("r37_dbg_data2", dbg_data, mem[2]);
                dbg_req = 1'b0;
            end
        end
        chk("r37_if_data_held", if_data, if_keep);

        // Reset during the READ cycle of a fetch abandons it
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h4; push_exp(1'b0, 32'h4);
        @(negedge clk);
        chk("r38_mem_ce_read", 32'(mem_ce), 32'h1);
        rst = 1'b1; if_req = 1'b0;
        @(negedge clk);
        chk_reset_outputs("r38_reset");
        q_if.delete();
        fetch_while_dbg = 0;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("r38_no_ack_%0d", k), 32'(if_ack), 32'h0);
        end
        if_req = 1'b1; if_addr = 32'h0; push_exp(1'b0, 32'h0);
        @(negedge clk);
        chk("r38_reissue_early", 32'(if_ack), 32'h0);
        @(negedge clk);
        chk("r38_reissue_ack", 32'(if_ack), 32'h1);
        chk("r38_reissue_data", if_data, 32'h34011100);
        if_req = 1'b0;
        @(negedge clk);

        // Randomized traffic on both ports
        fetch_while_dbg = 0;
        fork
            drive_port(1'b0, 40);
            drive_port(1'b1, 40);
        join
        repeat (4) @(negedge clk);
        chk("rand_drained", 32'(q_if.size() + q_dbg.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
